// File: rtl/uart_rom_loader.sv
// uart_rom_loader
//   Receives a program image over an 8N1 UART (LSB first) and writes it word
//   by word into the instruction ROM write port, holding the core in reset
//   while a load is in progress.
//   Image format: 16-bit little-endian word count, then count*4 bytes,
//   each word assembled little-endian.
// Ports
//   clk        : system clock, all state on posedge
//   rst_n      : asynchronous active-low reset
//   uart_rx    : asynchronous serial input, idle high
//   load_req   : 1-cycle pulse starting a load (accepted in idle/done/err)
//   core_rst_n : active-low reset to the core
//   rom_we     : ROM write strobe, one cycle per word
//   rom_waddr  : ROM word address for rom_we
//   rom_wdata  : ROM write data
//   busy/done/err : loader status
module uart_rom_loader #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic              load_req,
  output logic              core_rst_n,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CPB   = CLK_HZ / BAUD;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  // ---------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_vld_q, byte_vld_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= R_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    clk_cnt_d   = clk_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (rx_state_q)
      R_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_sync_q) begin
          rx_state_d = R_START;
          bit_cnt_d  = '0;
        end
      end
      R_START: begin
        // Mid-start-bit resample rejects short glitches.
        if (clk_cnt_q == CNT_W'(HALF - 1)) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (clk_cnt_q == CNT_W'(CPB - 1)) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) rx_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (clk_cnt_q == CNT_W'(CPB - 1)) begin
          clk_cnt_d   = '0;
          byte_vld_d  = rx_sync_q;
          frame_err_d = ~rx_sync_q;
          rx_state_d  = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------
  // L_RST is the single cycle after reset release, keeping core_rst_n low
  // for one clock before the core is allowed to run the existing ROM.
  typedef enum logic [2:0] {L_RST, L_IDLE, L_CNT0, L_CNT1, L_DATA, L_DONE, L_ERR} ld_state_t;

  ld_state_t         ld_state_q, ld_state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       word_q, word_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_waddr_q, rom_waddr_d;
  logic [31:0]       rom_wdata_q, rom_wdata_d;
  logic [15:0]       hdr_cnt;

  assign hdr_cnt = {shift_q, cnt_q[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state_q  <= L_RST;
      cnt_q       <= '0;
      widx_q      <= '0;
      bidx_q      <= '0;
      word_q      <= '0;
      rom_we_q    <= 1'b0;
      rom_waddr_q <= '0;
      rom_wdata_q <= '0;
    end else begin
      ld_state_q  <= ld_state_d;
      cnt_q       <= cnt_d;
      widx_q      <= widx_d;
      bidx_q      <= bidx_d;
      word_q      <= word_d;
      rom_we_q    <= rom_we_d;
      rom_waddr_q <= rom_waddr_d;
      rom_wdata_q <= rom_wdata_d;
    end
  end

  always_comb begin
    ld_state_d  = ld_state_q;
    cnt_d       = cnt_q;
    widx_d      = widx_q;
    bidx_d      = bidx_q;
    word_d      = word_q;
    rom_we_d    = 1'b0;
    rom_waddr_d = rom_waddr_q;
    rom_wdata_d = rom_wdata_q;
    unique case (ld_state_q)
      L_RST: ld_state_d = L_IDLE;
      L_IDLE, L_DONE, L_ERR: begin
        if (load_req) begin
          ld_state_d = L_CNT0;
          widx_d     = '0;
          bidx_d     = '0;
        end
      end
      L_CNT0: begin
        if (frame_err_q) begin
          ld_state_d = L_ERR;
        end else if (byte_vld_q) begin
          cnt_d[7:0] = shift_q;
          ld_state_d = L_CNT1;
        end
      end
      L_CNT1: begin
        if (frame_err_q) begin
          ld_state_d = L_ERR;
        end else if (byte_vld_q) begin
          cnt_d = hdr_cnt;
          if (hdr_cnt == 16'd0)                  ld_state_d = L_DONE;
          else if ({1'b0, hdr_cnt} > MAX_WORDS)  ld_state_d = L_ERR;
          else                                   ld_state_d = L_DATA;
        end
      end
      L_DATA: begin
        if (frame_err_q) begin
          ld_state_d = L_ERR;
        end else if (rom_we_q && (17'(widx_q) == {1'b0, cnt_q})) begin
          // Leave only after the final strobe cycle has completed.
          ld_state_d = L_DONE;
        end else if (byte_vld_q) begin
          bidx_d = bidx_q + 1'b1;
          unique case (bidx_q)
            2'd0: word_d[7:0]   = shift_q;
            2'd1: word_d[15:8]  = shift_q;
            2'd2: word_d[23:16] = shift_q;
            default: begin
              rom_we_d    = 1'b1;
              rom_waddr_d = widx_q[ADDR_W-1:0];
              rom_wdata_d = {shift_q, word_q};
              widx_d      = widx_q + 1'b1;
            end
          endcase
        end
      end
      default: ld_state_d = L_IDLE;
    endcase
  end

  assign core_rst_n = (ld_state_q == L_IDLE) || (ld_state_q == L_DONE);
  assign busy       = (ld_state_q == L_CNT0) || (ld_state_q == L_CNT1) || (ld_state_q == L_DATA);
  assign done       = (ld_state_q == L_DONE);
  assign err        = (ld_state_q == L_ERR);
  assign rom_we     = rom_we_q;
  assign rom_waddr  = rom_waddr_q;
  assign rom_wdata  = rom_wdata_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
module tb_uart_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        load_req_a = 1'b0;
  logic        load_req_b = 1'b0;

  logic        core_rst_n_a, rom_we_a, busy_a, done_a, err_a;
  logic [10:0] rom_waddr_a;
  logic [31:0] rom_wdata_a;
  logic        core_rst_n_b, rom_we_b, busy_b, done_b, err_b;
  logic [1:0]  rom_waddr_b;
  logic [31:0] rom_wdata_b;

  int checks = 0;
  int failures = 0;

  logic [10:0] wa_addr[$];
  logic [31:0] wa_data[$];
  logic [1:0]  wb_addr[$];
  logic [31:0] wb_data[$];

  always #5 clk = ~clk;

  uart_rom_loader #(.CLK_HZ(160), .BAUD(10), .ADDR_W(11)) dut_a (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .load_req(load_req_a),
    .core_rst_n(core_rst_n_a), .rom_we(rom_we_a), .rom_waddr(rom_waddr_a),
    .rom_wdata(rom_wdata_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  uart_rom_loader #(.CLK_HZ(160), .BAUD(10), .ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .load_req(load_req_b),
    .core_rst_n(core_rst_n_b), .rom_we(rom_we_b), .rom_waddr(rom_waddr_b),
    .rom_wdata(rom_wdata_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  always @(negedge clk) begin
    if (rom_we_a) begin wa_addr.push_back(rom_waddr_a); wa_data.push_back(rom_wdata_a); end
    if (rom_we_b) begin wb_addr.push_back(rom_waddr_b); wb_data.push_back(rom_wdata_b); end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = stop;
    repeat (15) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic pulse_a();
    @(negedge clk) load_req_a = 1'b1;
    @(negedge clk) load_req_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk) load_req_b = 1'b1;
    @(negedge clk) load_req_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // 1: reset and release
    #2;
    check_val("rst_core_rst_n", core_rst_n_a, 0);
    check_val("rst_rom_we", rom_we_a, 0);
    check_val("rst_waddr", rom_waddr_a, 0);
    check_val("rst_wdata", rom_wdata_a, 0);
    check_val("rst_busy_done_err", {busy_a, done_a, err_a}, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check_val("rel_core_rst_n_low", core_rst_n_a, 0);
    @(posedge clk); #1;
    check_val("rel_core_rst_n_high", core_rst_n_a, 1);
    idle(10);
    check_val("idle_busy", busy_a, 0);
    check_val("idle_no_writes", wa_addr.size(), 0);

    // 2: two-word image
    pulse_a();
    check_val("ld_busy", busy_a, 1);
    check_val("ld_core_rst", core_rst_n_a, 0);
    send_byte(8'h02, 1); send_byte(8'h00, 1);
    send_byte(8'hEF, 1); send_byte(8'hBE, 1); send_byte(8'hAD, 1); send_byte(8'hDE, 1);
    send_byte(8'h78, 1); send_byte(8'h56, 1); send_byte(8'h34, 1); send_byte(8'h12, 1);
    idle(4);
    check_val("t2_nwrites", wa_addr.size(), 2);
    if (wa_addr.size() == 2) begin
      check_val("t2_addr0", wa_addr[0], 0);
      check_val("t2_data0", wa_data[0], 32'hDEADBEEF);
      check_val("t2_addr1", wa_addr[1], 1);
      check_val("t2_data1", wa_data[1], 32'h12345678);
    end
    check_val("t2_done", {done_a, err_a, busy_a}, 3'b100);
    check_val("t2_core_rst_n", core_rst_n_a, 1);
    check_val("t2_waddr_hold", rom_waddr_a, 1);
    check_val("t2_wdata_hold", rom_wdata_a, 32'h12345678);

    // 3: empty image
    pulse_a();
    check_val("t3_core_rst_low", core_rst_n_a, 0);
    send_byte(8'h00, 1); send_byte(8'h00, 1);
    idle(4);
    check_val("t3_done", done_a, 1);
    check_val("t3_no_writes", wa_addr.size(), 2);
    check_val("t3_core_rst_n", core_rst_n_a, 1);

    // 4: framing error, then recovery
    pulse_a();
    send_byte(8'h01, 1); send_byte(8'h00, 1);
    send_byte(8'h55, 0);
    idle(20);
    check_val("t4_err", {err_a, done_a, busy_a}, 3'b100);
    check_val("t4_core_rst_n", core_rst_n_a, 0);
    check_val("t4_no_writes", wa_addr.size(), 2);
    idle(40);
    check_val("t4_core_rst_held", core_rst_n_a, 0);
    pulse_a();
    send_byte(8'h01, 1); send_byte(8'h00, 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
    idle(4);
    check_val("t4_done", {done_a, err_a}, 2'b10);
    check_val("t4_nwrites", wa_addr.size(), 3);
    if (wa_addr.size() == 3) begin
      check_val("t4_addr", wa_addr[2], 0);
      check_val("t4_data", wa_data[2], 32'h44332211);
    end

    // 5: ADDR_W=2 boundaries
    pulse_b();
    send_byte(8'h05, 1); send_byte(8'h00, 1);
    idle(4);
    check_val("t5_err", {err_b, busy_b}, 2'b10);
    check_val("t5_core_rst_n", core_rst_n_b, 0);
    pulse_b();
    send_byte(8'h04, 1); send_byte(8'h00, 1);
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1);
    idle(4);
    check_val("t5_nwrites", wb_addr.size(), 4);
    if (wb_addr.size() == 4) begin
      check_val("t5_addr0", wb_addr[0], 0);
      check_val("t5_data0", wb_data[0], 32'h13121110);
      check_val("t5_addr1", wb_addr[1], 1);
      check_val("t5_data1", wb_data[1], 32'h17161514);
      check_val("t5_addr2", wb_addr[2], 2);
      check_val("t5_data2", wb_data[2], 32'h1B1A1918);
      check_val("t5_addr3", wb_addr[3], 3);
      check_val("t5_data3", wb_data[3], 32'h1F1E1D1C);
    end
    check_val("t5_done", {done_b, err_b, core_rst_n_b}, 3'b101);
    check_val("t5_a_ignored", wa_addr.size(), 3);

    // 6a: short glitch must not produce a byte
    pulse_a();
    @(negedge clk) uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    idle(40);
    send_byte(8'h00, 1); send_byte(8'h00, 1);
    idle(4);
    check_val("t6_glitch_done", {done_a, busy_a}, 2'b10);

    // 6b: reset mid-word
    pulse_a();
    send_byte(8'h02, 1); send_byte(8'h00, 1);
    send_byte(8'hAA, 1); send_byte(8'hBB, 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_val("t6_rst_core", core_rst_n_a, 0);
    check_val("t6_rst_we", rom_we_a, 0);
    check_val("t6_rst_waddr", rom_waddr_a, 0);
    check_val("t6_rst_wdata", rom_wdata_a, 0);
    check_val("t6_rst_flags", {busy_a, done_a, err_a}, 0);
    check_val("t6_rst_b_wdata", rom_wdata_b, 0);
    check_val("t6_rst_b_core", core_rst_n_b, 0);
    check_val("t6_nwrites", wa_addr.size(), 3);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    check_val("t6_after_rel", {core_rst_n_a, busy_a, done_a, err_a}, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
